// File: rtl/seg7_reader_pkg.sv
// Shared segment encodings and types for the 7-segment reader.
// Active-low segment order is {g,f,e,d,c,b,a}; a lit segment reads as 0.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_e;

  typedef struct packed {
    logic       is_digit;
    logic       is_blank;
    logic [3:0] value;
  } pattern_t;

endpackage

// File: rtl/seg7_reader_if.sv
// Segment bus and decoded-digit signals between a display source and the reader.
// Optional lock_count member exists only when SEG7_READER_LOCK_COUNT_EN is defined.
interface seg7_reader_if;

  logic [6:0] seg_n;
  logic [3:0] digit;
  logic       valid;
  logic       locked;
  logic       err;
`ifdef SEG7_READER_LOCK_COUNT_EN
  logic [7:0] lock_count;

  modport master (output seg_n, input digit, valid, locked, err, lock_count);
  modport slave  (input seg_n, output digit, valid, locked, err, lock_count);
`else

  modport master (output seg_n, input digit, valid, locked, err);
  modport slave  (input seg_n, output digit, valid, locked, err);
`endif

endinterface

// File: rtl/seg7_pattern_lut.sv
// Combinational classifier: 7-bit active-low pattern -> {is_digit, is_blank, value}.
// Kept standalone so a display checker can reuse the same table.
module seg7_pattern_lut
  import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output pattern_t   info
);

    always_comb begin
        // NOTE: defaulting every field first keeps this purely combinational (no latch).
        info = '{is_digit: 1'b1, is_blank: 1'b0, value: 4'h0};
        case (pattern)
            SEG_0:     info.value = 4'h0;
            SEG_1:     info.value = 4'h1;
            SEG_2:     info.value = 4'h2;
            SEG_3:     info.value = 4'h3;
            SEG_4:     info.value = 4'h4;
            SEG_5:     info.value = 4'h5;
            SEG_6:     info.value = 4'h6;
            SEG_7:     info.value = 4'h7;
            SEG_8:     info.value = 4'h8;
            SEG_9:     info.value = 4'h9;
            SEG_A:     info.value = 4'hA;
            SEG_B:     info.value = 4'hB;
            SEG_C:     info.value = 4'hC;
            SEG_D:     info.value = 4'hD;
            SEG_E:     info.value = 4'hE;
            SEG_F:     info.value = 4'hF;
            SEG_BLANK: begin
                info.is_digit = 1'b0;
                info.is_blank = 1'b1;
            end
            default:   info.is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Recovers the hex digit shown on an active-low 7-segment bus after a stability filter.
// Define SEG7_READER_LOCK_COUNT_EN to add an 8-bit wrapping count of valid pulses.
module seg7_reader
  import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic          clk,
    input logic          rst,
    seg7_reader_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETTLE = SETTLE;
    localparam logic [1:0] ST_LOCKED = LOCKED;
    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    logic [6:0] s;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic [1:0] state;
    logic [3:0] digit_q;
    logic       valid_q;
    logic       locked_q;
    logic       err_q;
    pattern_t   info;
    logic       changed;
    logic       evaluate;
    logic       accept_new;

    seg7_pattern_lut u_lut (
        .pattern(bus.seg_n),
        .info   (info)
    );

    // A run is judged only while settling or on the edge it begins; with
    // STABLE_CYCLES=1 those coincide, so a fresh sample can be accepted at once.
    always_comb begin
        changed = (bus.seg_n != s);
        if (changed)
            cnt_next = 8'd1;
        else if (cnt == 8'hFF)
            cnt_next = cnt;
        else
            cnt_next = cnt + 8'd1;
        evaluate   = (cnt_next == STABLE_CNT) && (changed || state == ST_SETTLE);
        accept_new = evaluate && info.is_digit && (!locked_q || info.value != digit_q);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s        <= SEG_BLANK;
            cnt      <= 8'd0;
            state    <= ST_IDLE;
            digit_q  <= 4'h0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s       <= bus.seg_n;
            cnt     <= cnt_next;
            valid_q <= accept_new;
            if (evaluate) begin
                if (info.is_digit) begin
                    state    <= ST_LOCKED;
                    locked_q <= 1'b1;
                    err_q    <= 1'b0;
                    digit_q  <= info.value;
                end else begin
                    state    <= ST_IDLE;
                    locked_q <= 1'b0;
                    if (!info.is_blank)
                        err_q <= 1'b1;
                end
            end else if (changed) begin
                // Leaving LOCKED keeps locked_q high so a returning glitch stays silent.
                state <= ST_SETTLE;
            end
        end
    end

    assign bus.digit  = digit_q;
    assign bus.valid  = valid_q;
    assign bus.locked = locked_q;
    assign bus.err    = err_q;

`ifdef SEG7_READER_LOCK_COUNT_EN
    logic [7:0] lock_count_q;

    always_ff @(posedge clk) begin
        if (rst)
            lock_count_q <= 8'd0;
        else if (accept_new)
            lock_count_q <= lock_count_q + 8'd1;
    end

    assign bus.lock_count = lock_count_q;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Directed and randomized bench for seg7_reader against a run-length reference model.
// Build with SEG7_READER_LOCK_COUNT_EN defined to also exercise lock_count.
module tb_seg7_reader;

    localparam int unsigned N = 4;
    localparam logic [6:0] PATTERNS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg7_reader_if bus ();

    seg7_reader #(.STABLE_CYCLES(N)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    logic prev_valid = 1'b0;

    // Reference model: length of the current run of identical samples plus outputs.
    int unsigned m_run   = 0;
    logic [6:0]  m_prev  = 7'h7F;
    logic [3:0]  m_digit = 4'h0;
    logic        m_valid = 1'b0;
    logic        m_locked = 1'b0;
    logic        m_err   = 1'b0;
    logic [7:0]  m_lc    = 8'd0;

    function automatic int lookup(input logic [6:0] x);
        for (int i = 0; i < 16; i++)
            if (PATTERNS[i] == x) return i;
        return -1;
    endfunction

    task automatic model_edge(input logic [6:0] x, input logic r);
        int v;
        if (r) begin
            m_run = 0; m_prev = 7'h7F; m_digit = 4'h0;
            m_valid = 1'b0; m_locked = 1'b0; m_err = 1'b0; m_lc = 8'd0;
        end else begin
            m_run   = (x == m_prev) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
            m_prev  = x;
            m_valid = 1'b0;
            if (m_run == N) begin
                v = lookup(x);
                if (v >= 0) begin
                    m_valid  = !m_locked || (v[3:0] != m_digit);
                    m_digit  = v[3:0];
                    m_locked = 1'b1;
                    m_err    = 1'b0;
                    if (m_valid) m_lc = m_lc + 8'd1;
                end else begin
                    m_locked = 1'b0;
                    if (x != 7'h7F) m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [6:0] x, input logic r);
        bus.seg_n = x;
        rst       = r;
        @(posedge clk);
        #1;
        model_edge(x, r);
        check("digit",  8'(bus.digit),  8'(m_digit));
        check("valid",  8'(bus.valid),  8'(m_valid));
        check("locked", 8'(bus.locked), 8'(m_locked));
        check("err",    8'(bus.err),    8'(m_err));
`ifdef SEG7_READER_LOCK_COUNT_EN
        check("lock_count", bus.lock_count, m_lc);
`endif
        check("valid_gap", 8'(prev_valid && bus.valid), 8'd0);
        prev_valid = bus.valid;
        if (bus.valid === 1'b1) n_valid++;
    endtask

    initial begin
        int win;
        int len;
        int sel;
        logic [6:0] x;
        logic rr;

        bus.seg_n = 7'h7F;

        // Reset.
        tick(7'h7F, 1'b1);
        tick(7'h7F, 1'b1);
        check("rst_digit",  8'(bus.digit),  8'h0);
        check("rst_locked", 8'(bus.locked), 8'h0);

        // First lock on digit 0: pulse exactly on the 4th sampling edge.
        win = n_valid;
        for (int i = 0; i < 10; i++) begin
            tick(7'h40, 1'b0);
            check("lock0_pulse", 8'(bus.valid), 8'(i == N - 1));
        end
        check("lock0_count",  8'(n_valid - win), 8'd1);
        check("lock0_locked", 8'(bus.locked), 8'd1);

        // Glitch to 2 and back: silent.
        win = n_valid;
        tick(7'h24, 1'b0);
        tick(7'h24, 1'b0);
        for (int i = 0; i < 6; i++) tick(7'h40, 1'b0);
        check("glitch_count",  8'(n_valid - win), 8'd0);
        check("glitch_digit",  8'(bus.digit), 8'h0);
        check("glitch_locked", 8'(bus.locked), 8'd1);

        // Unlock via blank, then sweep all sixteen digits.
        for (int i = 0; i < 6; i++) tick(7'h7F, 1'b0);
        win = n_valid;
        for (int d = 0; d < 16; d++) begin
            for (int i = 0; i < 6; i++) tick(PATTERNS[d], 1'b0);
            check("sweep_digit", 8'(bus.digit), 8'(d));
        end
        check("sweep_count", 8'(n_valid - win), 8'd16);
        check("sweep_err",   8'(bus.err), 8'd0);

        // Illegal pattern, then recovery on F.
        for (int i = 0; i < 5; i++) tick(7'h55, 1'b0);
        check("illegal_err",    8'(bus.err), 8'd1);
        check("illegal_locked", 8'(bus.locked), 8'd0);
        check("illegal_digit",  8'(bus.digit), 8'hF);
        win = n_valid;
        for (int i = 0; i < 4; i++) tick(7'h0E, 1'b0);
        check("recover_digit", 8'(bus.digit), 8'hF);
        check("recover_err",   8'(bus.err), 8'd0);
        check("recover_count", 8'(n_valid - win), 8'd1);

        // Blank, then reset in the middle of settling on 5.
        win = n_valid;
        for (int i = 0; i < 6; i++) tick(7'h7F, 1'b0);
        check("blank_locked", 8'(bus.locked), 8'd0);
        check("blank_count",  8'(n_valid - win), 8'd0);
        tick(7'h12, 1'b0);
        tick(7'h12, 1'b0);
        tick(7'h12, 1'b1);
        check("midrst_digit",  8'(bus.digit), 8'h0);
        check("midrst_valid",  8'(bus.valid), 8'd0);
        check("midrst_locked", 8'(bus.locked), 8'd0);
        check("midrst_err",    8'(bus.err), 8'd0);
        for (int i = 0; i < 5; i++) tick(7'h12, 1'b0);
        check("postrst_digit", 8'(bus.digit), 8'h5);

        // Fast toggling changes nothing.
        win = n_valid;
        for (int i = 0; i < 20; i++) tick((i % 2) ? 7'h79 : 7'h40, 1'b0);
        check("toggle_count", 8'(n_valid - win), 8'd0);
        check("toggle_digit", 8'(bus.digit), 8'h5);

        // Randomized runs against the model.
        for (int k = 0; k < 400; k++) begin
            sel = $urandom_range(0, 99);
            if (sel < 60)      x = PATTERNS[$urandom_range(0, 15)];
            else if (sel < 75) x = 7'h7F;
            else               x = 7'($urandom);
            len = $urandom_range(1, 7);
            rr  = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < len; i++) tick(x, rr && (i == 0));
        end

`ifdef SEG7_READER_LOCK_COUNT_EN
        // 257 accepted changes wrap the counter to 1.
        tick(7'h7F, 1'b1);
        for (int k = 0; k < 257; k++)
            for (int i = 0; i < N; i++) tick((k % 2) ? 7'h79 : 7'h40, 1'b0);
        check("lock_count_wrap", bus.lock_count, 8'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
